byte_serializer: RTL and testbench

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/byte_serializer.sv | 93 +++++++++
 tb/tb_byte_serializer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/byte_serializer.sv
// byte_serializer: byte FIFO feeding an MSB-first shift register, one byte per 8 cycles.
// Popped bytes reload on the last bit of the previous byte so back-to-back bytes have no idle gap.
module byte_serializer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       sout,
    output logic       sout_valid,
    output logic       sout_first,
    output logic       sout_last,
    output logic       busy,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem_q [DEPTH];
    logic          push, pop, nonempty, shifting;

    assign din_ready = count_q < FULL;
    assign nonempty  = count_q != '0;
    assign push      = din_valid && din_ready;
    assign shifting  = state_q == SHIFT;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;
        // Reload happens both from IDLE and on the last bit of a byte
        if (!shifting || bit_cnt_q == 3'd0) begin
            if (nonempty) begin
                pop       = 1'b1;
                shift_d   = mem_q[rd_ptr_q];
                bit_cnt_d = 3'd7;
                state_d   = SHIFT;
            end else begin
                state_d   = IDLE;
            end
        end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 3'd1;
        end
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
        overflow_d = overflow_q || (din_valid && !din_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign sout       = shifting && shift_q[7];
    assign sout_valid = shifting;
    assign sout_first = shifting && bit_cnt_q == 3'd7;
    assign sout_last  = shifting && bit_cnt_q == 3'd0;
    assign busy       = shifting || nonempty;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: randomized and directed stimulus against a queue-based model of the serializer.
module tb_byte_serializer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready, sout, sout_valid, sout_first, sout_last, busy, overflow;

    byte_serializer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .sout_valid(sout_valid), .sout_first(sout_first), .sout_last(sout_last),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model: queued bytes, byte being sent, and bits of it still to send (0 = idle)
    logic [7:0] fq [$];
    logic [7:0] acc [$];
    logic [7:0] cap [$];
    logic [7:0] cur = '0;
    int         rem = 0;
    logic       m_ovf = 1'b0;
    logic [7:0] asm_b = '0;

    always @(negedge clk) begin
        if (rst_n && sout_valid) begin
            asm_b = sout_first ? {7'b0, sout} : {asm_b[6:0], sout};
            if (sout_last) cap.push_back(asm_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        chk("din_ready", din_ready, fq.size() < DEPTH);
        chk("sout_valid", sout_valid, rem > 0);
        chk("sout", sout, rem > 0 ? cur[rem-1] : 1'b0);
        chk("sout_first", sout_first, rem == 8);
        chk("sout_last", sout_last, rem == 1);
        chk("busy", busy, rem > 0 || fq.size() > 0);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d);
        logic full;
        full = fq.size() >= DEPTH;
        if (v && full) m_ovf = 1'b1;
        if (rem > 1) rem--;
        else if (fq.size() > 0) begin
            cur = fq.pop_front();
            rem = 8;
        end else rem = 0;
        if (v && !full) begin
            fq.push_back(d);
            acc.push_back(d);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        din_valid = v;
        din = d;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge(v, d);
        #1;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_din_ready", din_ready, 1);
        chk("rst_sout", sout, 0);
        chk("rst_sout_valid", sout_valid, 0);
        chk("rst_sout_first", sout_first, 0);
        chk("rst_sout_last", sout_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        fq.delete();
        acc.delete();
        cap.delete();
        rem = 0;
        cur = '0;
        m_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 8'h00);
        #1;
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
        chk({tag, "_count"}, cap.size(), acc.size());
        for (int i = 0; i < acc.size() && i < cap.size(); i++) chk({tag, "_byte"}, cap[i], acc[i]);
        cap.delete();
        acc.delete();
    endtask

    initial begin
        int idx;
        int cyc;
        do_reset();

        tick(1'b1, 8'hA5);
        drain("single", 14);
        chk("single_busy_after", busy, 0);

        tick(1'b1, 8'h81);
        tick(1'b1, 8'h3C);
        tick(1'b1, 8'hFF);
        drain("b2b", 32);

        for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i));
        chk("ovf_flag", overflow, 1);
        chk("ovf_accepted", acc.size(), 5);
        drain("ovf", 50);

        do_reset();
        idx = 0;
        cyc = 0;
        while (idx < 3 * DEPTH + 1 && cyc < 2000) begin
            if (fq.size() < DEPTH) begin
                tick(1'b1, 8'(idx + 1));
                idx++;
            end else tick(1'b0, 8'h00);
            cyc++;
        end
        chk("wrap_sent", idx, 3 * DEPTH + 1);
        chk("wrap_accepted", acc.size(), 3 * DEPTH + 1);
        drain("wrap", 60);
        chk("wrap_ovf", overflow, 0);

        do_reset();
        for (int i = 0; i < 400; i++) tick($urandom_range(0, 3) != 0, 8'($urandom));
        drain("rand", 60);

        do_reset();
        tick(1'b1, 8'hF0);
        tick(1'b1, 8'h0F);
        cyc = 0;
        while (rem != 5 && cyc < 20) begin
            tick(1'b0, 8'h00);
            cyc++;
        end
        chk("midrst_reached_bit4", rem, 5);
        chk("midrst_sout_before", sout, 1);
        do_reset();
        for (int i = 0; i < 20; i++) tick(1'b0, 8'h00);
        chk("midrst_nothing_emitted", cap.size(), 0);
        tick(1'b1, 8'h5A);
        drain("post_rst", 14);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
